// File: rtl/ff_share_arb.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Optional per-requester lock keeps the grant on one requester for a burst.

module ff_share_arb_lane #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      ptr,
  output logic               win
);
  // Requesters visited before IDX when scanning upward from ptr, cyclically.
  logic [NUM_REQ-1:0] ahead;

  always_comb begin
    ahead = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (int'(ptr) <= IDX) ahead[j] = (j >= int'(ptr)) && (j < IDX);
      else                  ahead[j] = (j >= int'(ptr)) || (j < IDX);
    end
  end

  assign win = req[IDX] && !(|(ahead & req));
endmodule

module ff_share_arb #(
  parameter int               WIDTH   = 8,
  parameter int               NUM_REQ = 4,
  parameter logic [WIDTH-1:0] INIT    = '0,
  localparam int              OW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     locked,
  output logic [WIDTH-1:0]         q,
  output logic [OW-1:0]            q_owner,
  output logic                     q_valid,
  output logic [15:0]              wr_count
);
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [OW-1:0] LAST = OW'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [OW-1:0]      ptr, ptr_nxt, lo, lo_nxt;
  logic [NUM_REQ-1:0] rr_win, lo_oh;
  logic [OW-1:0]      widx;
  logic [WIDTH-1:0]   wdata;
  logic               any_gnt;

  // Wrap explicitly so a non-power-of-two NUM_REQ never lands on an unused index.
  function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ff_share_arb_lane #(.NUM_REQ(NUM_REQ), .OW(OW), .IDX(i)) u_lane (
      .req (req),
      .ptr (ptr),
      .win (rr_win[i])
    );
    assign lo_oh[i] = (lo == OW'(i));
  end

  // Gated by rst so an asserted reset drops the grant without waiting for an edge.
  always_comb begin
    gnt = '0;
    if (rst && !clr) gnt = (state == IDLE) ? rr_win : (lo_oh & req);
  end

  assign any_gnt = |gnt;
  assign locked  = (state == LOCKED);

  always_comb begin
    widx  = '0;
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        widx  = OW'(i);
        wdata = data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Lock release is judged on req/lock alone, so it still happens under clr.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          if (lock[widx]) begin
            state_nxt = LOCKED;
            lo_nxt    = widx;
          end else begin
            ptr_nxt = inc_mod(widx);
          end
        end
      end
      LOCKED: begin
        if (!req[lo] || !lock[lo]) begin
          state_nxt = IDLE;
          ptr_nxt   = inc_mod(lo);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lo    <= lo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= INIT;
      q_owner  <= '0;
      q_valid  <= 1'b0;
      wr_count <= '0;
    end else if (clr) begin
      q        <= INIT;
      q_owner  <= '0;
      q_valid  <= 1'b0;
      wr_count <= '0;
    end else if (any_gnt) begin
      q        <= wdata;
      q_owner  <= widx;
      q_valid  <= 1'b1;
      wr_count <= wr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_ff_share_arb.sv
// Bench for ff_share_arb: queue-free reference model on a 4-requester instance,
// plus directed literal checks on it and on a 3-requester instance.
module tb_ff_share_arb;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clr = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   gnt;
  logic           locked;
  logic [W-1:0]   q;
  logic [1:0]     q_owner;
  logic           q_valid;
  logic [15:0]    wr_count;

  logic           clr3 = 1'b0;
  logic [2:0]     req3 = '0;
  logic [2:0]     lock3 = '0;
  logic [3*W-1:0] data3 = '0;
  logic [2:0]     gnt3;
  logic           locked3;
  logic [W-1:0]   q3;
  logic [1:0]     q_owner3;
  logic           q_valid3;
  logic [15:0]    wr_count3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_share_arb #(.WIDTH(W), .NUM_REQ(N), .INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .lock(lock), .data(data),
    .gnt(gnt), .locked(locked), .q(q), .q_owner(q_owner), .q_valid(q_valid),
    .wr_count(wr_count)
  );

  ff_share_arb #(.WIDTH(W), .NUM_REQ(3), .INIT(8'h3C)) dut3 (
    .clk(clk), .rst(rst), .clr(clr3), .req(req3), .lock(lock3), .data(data3),
    .gnt(gnt3), .locked(locked3), .q(q3), .q_owner(q_owner3), .q_valid(q_valid3),
    .wr_count(wr_count3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural state after the most recent edge.
  bit         m_locked;
  int         m_ptr, m_lo, m_owner;
  logic [7:0] m_q;
  bit         m_valid;
  logic [15:0] m_cnt;

  always @(negedge clk) begin : model
    logic [N-1:0] eg;
    int w;
    if (!rst) begin
      m_locked = 0; m_ptr = 0; m_lo = 0; m_q = 8'h00;
      m_owner = 0; m_valid = 0; m_cnt = 16'h0;
    end
    eg = '0;
    w = -1;
    if (rst && !clr) begin
      if (m_locked) begin
        if (req[m_lo]) w = m_lo;
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("m_gnt",      32'(gnt),      32'(eg));
    chk("m_locked",   32'(locked),   32'(m_locked));
    chk("m_q",        32'(q),        32'(m_q));
    chk("m_q_owner",  32'(q_owner),  32'(m_owner));
    chk("m_q_valid",  32'(q_valid),  32'(m_valid));
    chk("m_wr_count", 32'(wr_count), 32'(m_cnt));
    if (rst) begin
      if (clr) begin
        m_q = 8'h00; m_owner = 0; m_valid = 0; m_cnt = 16'h0;
      end else if (w >= 0) begin
        m_q = data[w*W +: W]; m_owner = w; m_valid = 1; m_cnt = m_cnt + 16'h1;
      end
      if (m_locked) begin
        if (!req[m_lo] || !lock[m_lo]) begin
          m_locked = 0;
          m_ptr = (m_lo + 1) % N;
        end
      end else if (w >= 0) begin
        if (lock[w]) begin
          m_locked = 1;
          m_lo = w;
        end else begin
          m_ptr = (w + 1) % N;
        end
      end
    end
  end

  initial begin
    data  = {8'h13, 8'h12, 8'h11, 8'h10};
    data3 = {8'h22, 8'h21, 8'h20};
    for (int k = 0; k < 4; k++) begin
      req = N'($urandom);
      lock = N'($urandom);
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_locked", 32'(locked), 0);
      tick();
    end
    chk("rst_q", 32'(q), 0);
    chk("rst_valid", 32'(q_valid), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_q3", 32'(q3), 32'h3C);

    // Full request after reset: plain rotation on both instances.
    rst = 1'b1; lock = '0; req = 4'hF; req3 = 3'h7;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k < 6) chk("rr3_gnt", 32'(gnt3), 32'(1 << (k % 3)));
      tick();
      if (k == 5) req3 = '0;
    end
    chk("rr_cnt", 32'(wr_count), 8);
    chk("rr_owner", 32'(q_owner), 3);
    chk("rr_q", 32'(q), 32'h13);
    chk("rr3_cnt", 32'(wr_count3), 6);
    chk("rr3_owner", 32'(q_owner3), 2);
    chk("rr3_q", 32'(q3), 32'h22);
    chk("rr3_locked", 32'(locked3), 0);

    // Fairness skip from ptr=2.
    req = 4'b0010; tick();
    req = 4'b0011; #1; chk("fair_skip", 32'(gnt), 1);
    tick(); #1; chk("fair_next", 32'(gnt), 2);
    tick();

    // Lock burst by requester 2, then final beat.
    req = 4'hF; lock = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1; chk("burst_gnt", 32'(gnt), 4);
      tick(); chk("burst_locked", 32'(locked), 1);
    end
    lock = '0; #1; chk("final_beat", 32'(gnt), 4);
    tick();
    chk("release_locked", 32'(locked), 0);
    chk("release_owner", 32'(q_owner), 2);
    #1; chk("after_release", 32'(gnt), 8);
    tick();

    // Lock abandon with lo=1.
    req = 4'b0010; lock = 4'b0010; tick();
    chk("abandon_locked", 32'(locked), 1);
    req = 4'b1101; lock = '0; #1; chk("abandon_gnt", 32'(gnt), 0);
    tick();
    chk("abandon_cnt", 32'(wr_count), 17);
    chk("abandon_idle", 32'(locked), 0);
    req = 4'hF; #1; chk("abandon_ptr", 32'(gnt), 4);

    // Clear beats a same-cycle write.
    req = 4'b0001; data[7:0] = 8'hA5; clr = 1'b1;
    #1; chk("clr_gnt", 32'(gnt), 0);
    tick();
    chk("clr_q", 32'(q), 0);
    chk("clr_valid", 32'(q_valid), 0);
    chk("clr_cnt", 32'(wr_count), 0);
    clr = 1'b0; tick();
    chk("post_clr_q", 32'(q), 32'hA5);
    chk("post_clr_cnt", 32'(wr_count), 1);
    chk("post_clr_valid", 32'(q_valid), 1);

    // Clear coinciding with lock release.
    lock = 4'b0001; tick();
    chk("clrrel_locked", 32'(locked), 1);
    clr = 1'b1; lock = '0; #1; chk("clrrel_gnt", 32'(gnt), 0);
    tick(); clr = 1'b0;
    chk("clrrel_idle", 32'(locked), 0);
    chk("clrrel_cnt", 32'(wr_count), 0);
    req = 4'hF; #1; chk("clrrel_ptr", 32'(gnt), 2);
    tick();

    // Asynchronous reset in the middle of a burst.
    req = 4'b1000; lock = 4'b1000; tick();
    chk("mid_locked", 32'(locked), 1);
    rst = 1'b0; #1;
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    tick();
    rst = 1'b1; req = 4'hF; lock = '0; #1;
    chk("mid_rst_first", 32'(gnt), 1);
    tick();

    // Random traffic against the model.
    repeat (3000) begin
      req  = N'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      data = $urandom;
      clr  = ($urandom_range(0, 31) == 0);
      rst  = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1; clr = 1'b0;

    // Counter wrap.
    clr = 1'b1; tick(); clr = 1'b0;
    req = 4'b0001; lock = '0;
    repeat (65535) tick();
    chk("wrap_max", 32'(wr_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(wr_count), 0);
    chk("wrap_valid", 32'(q_valid), 1);
    req = '0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ff_share_arb.md
# ff_share_arb

Round-robin arbiter and write sequencer for a single shared WIDTH-bit enable-register. Up to NUM_REQ requesters compete for write access. The block grants one requester per cycle, drives the register's enable/data, and records the owner of the last write and a write count. Optional per-requester lock holds ownership across a multi-cycle burst. It sits between requesting datapath stages and a shared configuration/status register.

## Interface
- WIDTH, 8, data width of the shared register
- NUM_REQ, 4, number of requesters (legal range 2..16)
- INIT, 0, reset/clear value of the register
- OW = $clog2(NUM_REQ) (derived localparam), owner index width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- clr  input  1  synchronous clear of register contents and statistics
- req  input  NUM_REQ  per-requester write request, bit i = requester i
- lock  input  NUM_REQ  per-requester lock request; meaningful only with req[i]
- data  input  NUM_REQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  one-hot (or zero) grant, combinational
- locked  output  1  high while the arbiter is in LOCKED state
- q  output  WIDTH  shared register contents
- q_owner  output  OW  index of requester that performed the last write
- q_valid  output  1  register has been written since reset/clear
- wr_count  output  16  number of writes since reset/clear, wraps 0xFFFF→0

## Operation
- State: FSM {IDLE, LOCKED}, round-robin pointer ptr[OW], lock owner lo[OW].
- Reset (rst=0, immediate): state=IDLE, ptr=0, lo=0, q=INIT, q_owner=0, q_valid=0, wr_count=0.
- IDLE grant: scan req starting at index ptr, ascending modulo NUM_REQ; first set bit i wins, gnt=onehot(i). No req → gnt=0.
- Write on every edge with gnt[i]=1 and clr=0: q<=data[i], q_owner<=i, q_valid<=1, wr_count<=wr_count+1.
- After an IDLE grant to i: if lock[i]=1, state<=LOCKED and lo<=i, ptr unchanged. Otherwise ptr<=(i+1) mod NUM_REQ.
- LOCKED: gnt=onehot(lo) if req[lo], else gnt=0. All other requests are ignored.
- LOCKED→IDLE at the edge where req[lo]=0 or lock[lo]=0; ptr<=(lo+1) mod NUM_REQ. If req[lo]=1 and lock[lo]=0, that cycle is still granted and written (final beat).
- clr=1: gnt forced to 0 that cycle. Register, q_valid and wr_count are reloaded with INIT, 0 and 0, and q_owner with 0. State, ptr and lo are unchanged. clr has priority over any write.
- Mod arithmetic: when NUM_REQ is not a power of two, ptr wraps from NUM_REQ-1 to 0, never to an unused index.
- Requesters must hold data stable while req is high. gnt is valid only in the cycle it is asserted.

## Timing
- gnt: zero-cycle combinational from req, lock, clr, state, ptr and lo. No combinational path from data to gnt.
- Write latency: q, q_owner, q_valid and wr_count reflect a grant one edge after the cycle gnt was high.
- Throughput: one write per cycle sustained. There are no idle bubbles between different winners.
- locked rises the cycle after the locking grant and falls the cycle after the release edge.
- Reset mid-burst: an asynchronous assert drops locked and gnt immediately. Deassertion is synchronized externally; the first active edge behaves as IDLE with ptr=0.
- Simultaneous clr and lock release: the release still takes effect (state/ptr update) while the write is suppressed.

## Test plan
- Reset: hold rst=0 with random req → gnt=0, q=INIT, q_valid=0, wr_count=0, locked=0. Release, then req=4'b1111 for 8 cycles (NUM_REQ=4) → grants 0,1,2,3,0,1,2,3; wr_count=8; q_owner=3.
- Fairness skip: ptr=2, req=4'b0011 → gnt=4'b0001 and ptr becomes 1. Next cycle, same req → gnt=4'b0010.
- Lock burst: requester 2 asserts req+lock for 3 cycles while others request → gnt=4'b0100 three times, locked high. Drop lock with req high → one more write by 2, then IDLE and the next grant goes to 3.
- Lock abandon: in LOCKED with lo=1, req[1] drops → that cycle gnt=0, no write, wr_count unchanged, state→IDLE, ptr=2.
- Clear: req[0]=1 with data0=8'hA5 and clr=1 in the same cycle → gnt=0, q=INIT, q_valid=0, wr_count=0. Next cycle with clr=0 → q=8'hA5, wr_count=1.
- Wrap and edge cases: NUM_REQ=3, full request for 6 cycles → order 0,1,2,0,1,2 and ptr never equals 3. Preload 0xFFFF writes → wr_count wraps to 0.
